// File: rtl/fir_seq_ctrl.sv
// Purpose : loads N_TAPS coefficients over a valid/ready stream, then flushes
//           the FIR delay line and enables the filter.
// Latency : cfg_start -> cfg_ready is 1 cycle. The last accepted word -> out_valid is N_TAPS+1 cycles.
// Backpressure: cfg_ready is high only in LOAD. A cfg_valid gap holds the load position.
//
// Ports:
//   clk, rst        - clock and asynchronous active-low reset
//   cfg_start       - begin or restart a configuration from any state
//   cfg_valid/ready - coefficient word handshake. cfg_data is the two's complement word.
//   coef_flat       - registered coefficients. Tap k is at [k*BW_coef +: BW_coef].
//   clear_dl        - one-cycle pulse that zeroes the FIR delay line
//   fir_en          - FIR shift/accumulate enable (FLUSH and RUN)
//   out_valid       - FIR output is meaningful (RUN)
//   load_done       - one-cycle pulse after the last coefficient is accepted
module fir_seq_ctrl #(
    parameter int N_TAPS  = 4,
    parameter int BW_coef = 6,
    parameter int IDX_W   = $clog2(N_TAPS + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cfg_start,
    input  logic                      cfg_valid,
    input  logic [BW_coef-1:0]        cfg_data,
    output logic                      cfg_ready,
    output logic [N_TAPS*BW_coef-1:0] coef_flat,
    output logic                      clear_dl,
    output logic                      fir_en,
    output logic                      out_valid,
    output logic                      load_done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2,
        RUN   = 2'd3
    } state_t;

    localparam logic [IDX_W-1:0] LAST = IDX_W'(N_TAPS - 1);

    state_t                      state_q, state_d;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic [IDX_W-1:0]            flush_cnt_q, flush_cnt_d;
    logic [N_TAPS*BW_coef-1:0]   coef_q, coef_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            flush_cnt_q <= '0;
            coef_q      <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            flush_cnt_q <= flush_cnt_d;
            coef_q      <= coef_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        flush_cnt_d = flush_cnt_q;
        coef_d      = coef_q;

        case (state_q)
            IDLE: begin
                // cfg_valid is deliberately ignored here, even alongside cfg_start.
                if (cfg_start) begin
                    state_d = LOAD;
                    idx_d   = '0;
                end
            end

            LOAD: begin
                if (cfg_start) begin
                    // A restart discards any word offered in the same cycle.
                    idx_d = '0;
                end else if (cfg_valid) begin
                    for (int k = 0; k < N_TAPS; k++) begin
                        if (idx_q == IDX_W'(k)) begin
                            coef_d[k*BW_coef +: BW_coef] = cfg_data;
                        end
                    end
                    if (idx_q == LAST) begin
                        state_d     = FLUSH;
                        idx_d       = '0;
                        flush_cnt_d = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end

            FLUSH: begin
                if (cfg_start) begin
                    state_d = LOAD;
                    idx_d   = '0;
                end else if (flush_cnt_q == LAST) begin
                    state_d = RUN;
                end else begin
                    flush_cnt_d = flush_cnt_q + IDX_W'(1);
                end
            end

            RUN: begin
                if (cfg_start) begin
                    state_d = LOAD;
                    idx_d   = '0;
                end
            end

            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // FLUSH can only be entered from the final LOAD transfer with flush_cnt
    // cleared. So its first cycle marks both load completion and the delay-line clear.
    assign cfg_ready = (state_q == LOAD);
    assign fir_en    = (state_q == FLUSH) || (state_q == RUN);
    assign out_valid = (state_q == RUN);
    assign clear_dl  = (state_q == FLUSH) && (flush_cnt_q == '0);
    assign load_done = (state_q == FLUSH) && (flush_cnt_q == '0);
    assign coef_flat = coef_q;

endmodule

// File: tb/tb_fir_seq_ctrl.sv
module tb_fir_seq_ctrl;

    logic        clk       = 1'b0;
    logic        rst       = 1'b1;
    logic        cfg_start = 1'b0;
    logic        cfg_valid = 1'b0;
    logic [5:0]  cfg_data  = 6'd0;
    logic        cfg_ready;
    logic [23:0] coef_flat;
    logic        clear_dl;
    logic        fir_en;
    logic        out_valid;
    logic        load_done;

    int n_cmp = 0;
    int n_err = 0;

    logic [23:0] exp_coef;

    fir_seq_ctrl #(.N_TAPS(4), .BW_coef(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_start (cfg_start),
        .cfg_valid (cfg_valid),
        .cfg_data  (cfg_data),
        .cfg_ready (cfg_ready),
        .coef_flat (coef_flat),
        .clear_dl  (clear_dl),
        .fir_en    (fir_en),
        .out_valid (out_valid),
        .load_done (load_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [5:0] w);
        cfg_valid = 1'b1;
        cfg_data  = w;
        tick();
        cfg_valid = 1'b0;
    endtask

    initial begin
        // Asynchronous reset: outputs must be zero before any clock edge.
        #2 rst = 1'b0;
        #1;
        chk("rst_coef",  coef_flat, 24'h0);
        chk("rst_ready", cfg_ready, 0);
        chk("rst_fir",   fir_en,    0);
        chk("rst_ov",    out_valid, 0);
        chk("rst_clr",   clear_dl,  0);
        chk("rst_ld",    load_done, 0);
        tick();
        tick();
        rst = 1'b1;

        // Idle for 10 cycles.
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_coef",  coef_flat, 24'h0);
            chk("idle_fir",   fir_en,    0);
            chk("idle_ov",    out_valid, 0);
            chk("idle_ready", cfg_ready, 0);
        end

        // Load words 1, 2, 3 and -4 back to back.
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        chk("start_ready", cfg_ready, 1);
        chk("start_ld",    load_done, 0);
        send(6'd1);
        chk("coef_w1", coef_flat, 24'h000001);
        send(6'd2);
        send(6'd3);
        send(6'h3C);
        chk("ld_pulse",   load_done, 1);
        chk("clr_pulse",  clear_dl,  1);
        chk("flush_fir",  fir_en,    1);
        chk("flush_ov",   out_valid, 0);
        chk("flush_rdy",  cfg_ready, 0);
        chk("coef_load1", coef_flat, 24'hF03081);
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("ov_lat",   out_valid, (i == 4) ? 1 : 0);
            chk("ld_once",  load_done, 0);
            chk("clr_once", clear_dl,  0);
        end
        chk("run_fir", fir_en, 1);

        // Reload the same words with a 3-cycle valid gap between words 2 and 3.
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        chk("rl_ov",    out_valid, 0);
        chk("rl_fir",   fir_en,    0);
        chk("rl_ready", cfg_ready, 1);
        send(6'd1);
        send(6'd2);
        cfg_data = 6'h2A;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("gap_coef",  coef_flat, 24'hF03081);
            chk("gap_ready", cfg_ready, 1);
        end
        send(6'd3);
        send(6'h3C);
        chk("gap_ld", load_done, 1);
        repeat (4) tick();
        chk("gap_ov",   out_valid, 1);
        chk("gap_coef", coef_flat, 24'hF03081);

        // Reconfigure from RUN with 5, 5, 5, 5. Taps update one per transfer.
        exp_coef  = 24'hF03081;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        chk("r5_ov",  out_valid, 0);
        chk("r5_fir", fir_en,    0);
        for (int k = 0; k < 4; k++) begin
            send(6'd5);
            exp_coef[k*6 +: 6] = 6'd5;
            chk("r5_coef", coef_flat, exp_coef);
        end
        chk("r5_final", coef_flat, 24'h145145);
        chk("r5_clr",   clear_dl,  1);
        repeat (4) tick();
        chk("r5_run", out_valid, 1);

        // Assert cfg_start in the first FLUSH cycle to abort back to LOAD.
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        for (int k = 0; k < 4; k++) send(6'd1);
        chk("fl_fir0", fir_en, 1);
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        chk("fl_fir",   fir_en,    0);
        chk("fl_ready", cfg_ready, 1);
        chk("fl_coef",  coef_flat, 24'h041041);

        // Reset to reach IDLE.
        rst = 1'b0;
        #1;
        chk("rst2_coef",  coef_flat, 24'h0);
        chk("rst2_ready", cfg_ready, 0);
        tick();
        rst = 1'b1;

        // A word offered together with cfg_start in IDLE is dropped.
        cfg_start = 1'b1;
        cfg_valid = 1'b1;
        cfg_data  = 6'd7;
        tick();
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
        chk("drop_coef",  coef_flat, 24'h0);
        chk("drop_ready", cfg_ready, 1);
        send(6'd9);
        chk("drop_next", coef_flat, 24'h000009);

        // A restart in LOAD discards the same-cycle word and rewinds the index.
        cfg_start = 1'b1;
        send(6'h11);
        cfg_start = 1'b0;
        chk("restart_drop", coef_flat, 24'h000009);
        send(6'h0A);
        chk("restart_w0", coef_flat, 24'h00000A);
        send(6'h0B);
        chk("restart_w1", coef_flat, 24'h0002CA);

        // Reset after 2 of 4 words clears all taps with no clock edge.
        rst = 1'b0;
        #1;
        chk("midrst_coef",  coef_flat, 24'h0);
        chk("midrst_ready", cfg_ready, 0);
        chk("midrst_fir",   fir_en,    0);
        #1 rst = 1'b1;
        tick();
        chk("midrst_idle", cfg_ready, 0);
        cfg_valid = 1'b1;
        cfg_data  = 6'd3;
        tick();
        cfg_valid = 1'b0;
        chk("idle_ignore", coef_flat, 24'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
